// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: funct3 access sizes, trap causes, sequencer states.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package lsu_pkg;

  // funct3 encodings for loads/stores
  localparam logic [2:0] LS_B  = 3'b000;
  localparam logic [2:0] LS_H  = 3'b001;
  localparam logic [2:0] LS_W  = 3'b010;
  localparam logic [2:0] LS_BU = 3'b100;
  localparam logic [2:0] LS_HU = 3'b101;

  // mcause values for misaligned accesses
  localparam logic [3:0] EXC_LOAD_MISALIGN  = 4'd4;
  localparam logic [3:0] EXC_STORE_MISALIGN = 4'd6;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_LOAD_DATA = 2'd2,
    ST_STORE_WR  = 2'd3
  } lsu_state_t;

endpackage

// File: rtl/lsu_align_check.sv
// Flags an access whose byte address is not a multiple of its size (H/HU on odd, W off word boundary).
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle.
module lsu_align_check
  import lsu_pkg::*;
(
  input  logic [2:0] i_type,
  input  logic [1:0] i_addr_lo,
  output logic       o_misaligned
);

  // byte accesses are always aligned; unknown encodings are not flagged here
  always_comb begin
    o_misaligned = 1'b0;
    case (i_type)
      LS_H, LS_HU: o_misaligned = i_addr_lo[0];
      LS_W:        o_misaligned = |i_addr_lo;
      default:     o_misaligned = 1'b0;
    endcase
  end

endmodule

// File: rtl/lsu_sequencer.sv
// Sequences one EX-stage memory request at a time onto registered data-memory control lines.
// Latency: load accept -> wb_valid 2 cycles; store W busy 1 cycle, store B/H busy 2 (read then write).
// Backpressure: req_ready is high only in IDLE; misaligned or no-op requests are absorbed in IDLE.
module lsu_sequencer
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_W   = 5
) (
  input  logic              cpu_clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_load,
  input  logic              req_store,
  input  logic [2:0]        req_type,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [RD_W-1:0]   req_rd,
  output logic              mem_load,
  output logic              mem_store,
  output logic [2:0]        mem_type,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_q,
  output logic              wb_valid,
  output logic [RD_W-1:0]   wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              exc_valid,
  output logic [3:0]        exc_cause,
  output logic [ADDR_W-1:0] exc_addr
);

  lsu_state_t r_state;
  lsu_state_t w_state_nxt;

  logic              r_is_load;
  logic              r_mem_load;
  logic              r_mem_store;
  logic [2:0]        r_mem_type;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [RD_W-1:0]   r_rd;
  logic              r_wb_vld;
  logic [RD_W-1:0]   r_wb_rd;
  logic [DATA_W-1:0] r_wb_data;
  logic              r_exc_vld;
  logic [3:0]        r_exc_cause;
  logic [ADDR_W-1:0] r_exc_addr;

  logic w_accept;
  logic w_is_load;
  logic w_is_store;
  logic w_misaligned;
  logic w_issue;
  logic w_exc;
  logic w_mem_load_nxt;
  logic w_mem_store_nxt;
  logic w_wb_fire;

  lsu_align_check u_align (
    .i_type       (req_type),
    .i_addr_lo    (req_addr[1:0]),
    .o_misaligned (w_misaligned)
  );

  // load wins when both direction bits are set
  assign req_ready  = (r_state == ST_IDLE);
  assign w_accept   = req_valid && req_ready;
  assign w_is_load  = req_load;
  assign w_is_store = req_store && !req_load;
  assign w_issue    = w_accept && (w_is_load || w_is_store) && !w_misaligned;
  assign w_exc      = w_accept && (w_is_load || w_is_store) && w_misaligned;

  // state register
  always_ff @(posedge cpu_clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // next state plus next value of the registered memory strobes
  always_comb begin
    w_state_nxt     = r_state;
    w_mem_load_nxt  = 1'b0;
    w_mem_store_nxt = 1'b0;
    w_wb_fire       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_issue) begin
          w_state_nxt     = ST_ISSUE;
          w_mem_load_nxt  = w_is_load;
          w_mem_store_nxt = w_is_store;
        end
      end
      ST_ISSUE: begin
        if (r_is_load) begin
          w_state_nxt = ST_LOAD_DATA;
        end else if (r_mem_type == LS_W) begin
          w_state_nxt = ST_IDLE;
        end else begin
          // sub-word store: memory reads in ISSUE, merges and writes in STORE_WR
          w_state_nxt     = ST_STORE_WR;
          w_mem_store_nxt = 1'b1;
        end
      end
      ST_LOAD_DATA: begin
        w_state_nxt = ST_IDLE;
        w_wb_fire   = 1'b1;
      end
      ST_STORE_WR: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // memory control lines and request latches; addr/type/wdata move only on accept
  always_ff @(posedge cpu_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_load  <= 1'b0;
      r_mem_store <= 1'b0;
      r_is_load   <= 1'b0;
      r_mem_type  <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_rd        <= '0;
    end else begin
      r_mem_load  <= w_mem_load_nxt;
      r_mem_store <= w_mem_store_nxt;
      if (w_accept) begin
        r_is_load   <= w_is_load;
        r_mem_type  <= req_type;
        r_mem_addr  <= req_addr;
        r_mem_wdata <= req_wdata;
        r_rd        <= req_rd;
      end
    end
  end

  // writeback and exception pulses; they are set from different states so never overlap
  always_ff @(posedge cpu_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wb_vld    <= 1'b0;
      r_wb_rd     <= '0;
      r_wb_data   <= '0;
      r_exc_vld   <= 1'b0;
      r_exc_cause <= '0;
      r_exc_addr  <= '0;
    end else begin
      r_wb_vld  <= w_wb_fire;
      r_exc_vld <= w_exc;
      if (w_wb_fire) begin
        r_wb_data <= mem_q;
        r_wb_rd   <= r_rd;
      end
      if (w_exc) begin
        r_exc_cause <= w_is_load ? EXC_LOAD_MISALIGN : EXC_STORE_MISALIGN;
        r_exc_addr  <= req_addr;
      end
    end
  end

  assign mem_load  = r_mem_load;
  assign mem_store = r_mem_store;
  assign mem_type  = r_mem_type;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign wb_valid  = r_wb_vld;
  assign wb_rd     = r_wb_rd;
  assign wb_data   = r_wb_data;
  assign exc_valid = r_exc_vld;
  assign exc_cause = r_exc_cause;
  assign exc_addr  = r_exc_addr;

endmodule

// File: tb/tb_lsu_sequencer.sv
// Bench for lsu_sequencer: directed scenarios followed by random requests against a transaction-level model.
// Latency: n/a.
// Backpressure: waits (bounded) on req_ready before each request.
module tb_lsu_sequencer;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int RD_W   = 5;

  logic              cpu_clk = 1'b0;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_load;
  logic              req_store;
  logic [2:0]        req_type;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [RD_W-1:0]   req_rd;
  logic              mem_load;
  logic              mem_store;
  logic [2:0]        mem_type;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_q;
  logic              wb_valid;
  logic [RD_W-1:0]   wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              exc_valid;
  logic [3:0]        exc_cause;
  logic [ADDR_W-1:0] exc_addr;

  int checks = 0;
  int errors = 0;

  always #5 cpu_clk = ~cpu_clk;

  lsu_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_W(RD_W)) dut (
    .cpu_clk   (cpu_clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_load  (req_load),
    .req_store (req_store),
    .req_type  (req_type),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_rd    (req_rd),
    .mem_load  (mem_load),
    .mem_store (mem_store),
    .mem_type  (mem_type),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_q     (mem_q),
    .wb_valid  (wb_valid),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .exc_valid (exc_valid),
    .exc_cause (exc_cause),
    .exc_addr  (exc_addr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // advance one clock; sample point is 1 time unit after the rising edge
  task automatic tick();
    @(posedge cpu_clk);
    #1;
    mem_q = $urandom;
  endtask

  // access size in bytes from funct3; aligned means the address is a multiple of it
  function automatic bit misaligned_ref(input logic [2:0] ty, input logic [31:0] ad);
    int size;
    size = (ty[1:0] == 2'd0) ? 1 : (ty[1:0] == 2'd1) ? 2 : 4;
    return (ad % size) != 0;
  endfunction

  // issue one request and check the whole transaction against the size/direction rules
  task automatic do_req(input bit ld, input bit st, input logic [2:0] ty, input logic [31:0] ad,
                        input logic [31:0] wd, input logic [4:0] rd, input bit hold);
    int          n;
    logic [31:0] qv;
    bit          is_ld;
    bit          is_st;
    bit          mis;
    n = 0;
    while (!req_ready && n < 8) begin
      tick();
      n++;
    end
    chk("ready_before_req", {31'd0, req_ready}, 32'd1);
    is_ld = ld;
    is_st = st && !ld;
    mis   = (is_ld || is_st) && misaligned_ref(ty, ad);
    req_valid = 1'b1;
    req_load  = ld;
    req_store = st;
    req_type  = ty;
    req_addr  = ad;
    req_wdata = wd;
    req_rd    = rd;
    tick();
    if (!hold) req_valid = 1'b0;
    chk("mem_addr_latched", mem_addr, ad);
    chk("mem_type_latched", {29'd0, mem_type}, {29'd0, ty});
    chk("mem_wdata_latched", mem_wdata, wd);
    if (!is_ld && !is_st) begin
      chk("noop_ready", {31'd0, req_ready}, 32'd1);
      chk("noop_mem_load", {31'd0, mem_load}, 32'd0);
      chk("noop_mem_store", {31'd0, mem_store}, 32'd0);
      chk("noop_exc", {31'd0, exc_valid}, 32'd0);
      chk("noop_wb", {31'd0, wb_valid}, 32'd0);
    end else if (mis) begin
      chk("mis_exc_valid", {31'd0, exc_valid}, 32'd1);
      chk("mis_exc_cause", {28'd0, exc_cause}, is_ld ? 32'd4 : 32'd6);
      chk("mis_exc_addr", exc_addr, ad);
      chk("mis_mem_load", {31'd0, mem_load}, 32'd0);
      chk("mis_mem_store", {31'd0, mem_store}, 32'd0);
      chk("mis_ready", {31'd0, req_ready}, 32'd1);
      chk("mis_wb", {31'd0, wb_valid}, 32'd0);
      tick();
      chk("mis_exc_pulse_end", {31'd0, exc_valid}, 32'd0);
    end else if (is_ld) begin
      chk("ld_issue_mem_load", {31'd0, mem_load}, 32'd1);
      chk("ld_issue_mem_store", {31'd0, mem_store}, 32'd0);
      chk("ld_issue_ready", {31'd0, req_ready}, 32'd0);
      tick();
      qv = mem_q;
      chk("ld_data_mem_load", {31'd0, mem_load}, 32'd0);
      chk("ld_data_ready", {31'd0, req_ready}, 32'd0);
      chk("ld_data_addr_held", mem_addr, ad);
      chk("ld_data_wb_early", {31'd0, wb_valid}, 32'd0);
      tick();
      chk("ld_wb_valid", {31'd0, wb_valid}, 32'd1);
      chk("ld_wb_data", wb_data, qv);
      chk("ld_wb_rd", {27'd0, wb_rd}, {27'd0, rd});
      chk("ld_wb_ready", {31'd0, req_ready}, 32'd1);
      chk("ld_wb_no_exc", {31'd0, exc_valid}, 32'd0);
    end else begin
      chk("st_issue_mem_store", {31'd0, mem_store}, 32'd1);
      chk("st_issue_mem_load", {31'd0, mem_load}, 32'd0);
      chk("st_issue_ready", {31'd0, req_ready}, 32'd0);
      if (ty != 3'b010) begin
        tick();
        chk("st_wr_mem_store", {31'd0, mem_store}, 32'd1);
        chk("st_wr_mem_load", {31'd0, mem_load}, 32'd0);
        chk("st_wr_addr_held", mem_addr, ad);
        chk("st_wr_wdata_held", mem_wdata, wd);
        chk("st_wr_type_held", {29'd0, mem_type}, {29'd0, ty});
        chk("st_wr_ready", {31'd0, req_ready}, 32'd0);
      end
      tick();
      chk("st_done_mem_store", {31'd0, mem_store}, 32'd0);
      chk("st_done_ready", {31'd0, req_ready}, 32'd1);
      chk("st_done_no_wb", {31'd0, wb_valid}, 32'd0);
    end
  endtask

  initial begin
    logic [2:0] ty;
    bit         ld;
    bit         st;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_load  = 1'b0;
    req_store = 1'b0;
    req_type  = '0;
    req_addr  = '0;
    req_wdata = '0;
    req_rd    = '0;
    mem_q     = '0;
    #1;
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_mem_load", {31'd0, mem_load}, 32'd0);
    chk("rst_mem_store", {31'd0, mem_store}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_type", {29'd0, mem_type}, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
    chk("rst_exc_valid", {31'd0, exc_valid}, 32'd0);
    chk("rst_exc_cause", {28'd0, exc_cause}, 32'd0);
    chk("rst_exc_addr", exc_addr, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // load word with a known memory value
    wait_ready_and_load_w();

    // directed sub-word store, word store, misaligned load/store
    do_req(1'b0, 1'b1, 3'b000, 32'h23, 32'hAA, 5'd0, 1'b0);
    do_req(1'b0, 1'b1, 3'b010, 32'h40, 32'h1234_5678, 5'd0, 1'b0);
    do_req(1'b1, 1'b0, 3'b001, 32'h41, 32'h0, 5'd7, 1'b0);
    do_req(1'b0, 1'b1, 3'b010, 32'h42, 32'h5555_AAAA, 5'd0, 1'b0);
    // both bits set acts as a load; neither bit set is a silent no-op
    do_req(1'b1, 1'b1, 3'b101, 32'h102, 32'h0, 5'd9, 1'b0);
    do_req(1'b0, 1'b0, 3'b010, 32'h200, 32'hCAFE_F00D, 5'd2, 1'b0);

    // reset while a sub-word store is in its write phase
    req_valid = 1'b1;
    req_load  = 1'b0;
    req_store = 1'b1;
    req_type  = 3'b001;
    req_addr  = 32'h66;
    req_wdata = 32'hBEEF;
    tick();
    req_valid = 1'b0;
    chk("rstmid_issue_store", {31'd0, mem_store}, 32'd1);
    tick();
    chk("rstmid_wr_store", {31'd0, mem_store}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstmid_store_drop", {31'd0, mem_store}, 32'd0);
    chk("rstmid_ready", {31'd0, req_ready}, 32'd1);
    chk("rstmid_addr_clear", mem_addr, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rstpost_ready", {31'd0, req_ready}, 32'd1);
      chk("rstpost_store", {31'd0, mem_store}, 32'd0);
      chk("rstpost_wb", {31'd0, wb_valid}, 32'd0);
      chk("rstpost_exc", {31'd0, exc_valid}, 32'd0);
    end

    // back-to-back: valid held through the load; store accepted in the writeback cycle
    do_req(1'b1, 1'b0, 3'b010, 32'h80, 32'h0, 5'd17, 1'b1);
    chk("b2b_wb_at_next_accept", {31'd0, wb_valid}, 32'd1);
    chk("b2b_wb_rd_order", {27'd0, wb_rd}, 32'd17);
    do_req(1'b0, 1'b1, 3'b001, 32'h86, 32'h0000_7777, 5'd0, 1'b0);

    // random traffic
    for (int k = 0; k < 40; k++) begin
      ld = $urandom_range(0, 1);
      st = $urandom_range(0, 1);
      if (st && !ld) begin
        case ($urandom_range(0, 2))
          0:       ty = 3'b000;
          1:       ty = 3'b001;
          default: ty = 3'b010;
        endcase
      end else begin
        case ($urandom_range(0, 4))
          0:       ty = 3'b000;
          1:       ty = 3'b001;
          2:       ty = 3'b010;
          3:       ty = 3'b100;
          default: ty = 3'b101;
        endcase
      end
      do_req(ld, st, ty, $urandom, $urandom, 5'($urandom_range(0, 31)), 1'b0);
      if ($urandom_range(0, 1) == 1) tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // word load at 0x10 returning a fixed memory word
  task automatic wait_ready_and_load_w();
    chk("ldw_ready", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_load  = 1'b1;
    req_store = 1'b0;
    req_type  = 3'b010;
    req_addr  = 32'h10;
    req_wdata = 32'h0;
    req_rd    = 5'd3;
    tick();
    req_valid = 1'b0;
    chk("ldw_mem_load", {31'd0, mem_load}, 32'd1);
    chk("ldw_mem_addr", mem_addr, 32'h10);
    tick();
    mem_q = 32'hDEAD_BEEF;
    chk("ldw_mem_load_off", {31'd0, mem_load}, 32'd0);
    chk("ldw_wb_not_yet", {31'd0, wb_valid}, 32'd0);
    tick();
    chk("ldw_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("ldw_wb_data", wb_data, 32'hDEAD_BEEF);
    chk("ldw_wb_rd", {27'd0, wb_rd}, 32'd3);
    tick();
    chk("ldw_wb_pulse_end", {31'd0, wb_valid}, 32'd0);
  endtask

endmodule
